// File: rtl/pong_telemetry_tx.sv
`default_nettype none
// ============================================================================
// Module   : pong_telemetry_tx
// Brief    : Watches score and game-phase signals and sends a 4-byte event
//            packet (sync, type, scores, checksum) over an 8N1 UART line.
// Revision : 1.0  initial release
// ============================================================================
module pong_telemetry_tx #(
    parameter int         CLK_FREQ  = 25_175_000,
    parameter int         BAUD      = 115200,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic [3:0] score_p1,
    input  logic [3:0] score_p2,
    input  logic       game_over,
    input  logic       game_startup,
    output logic       uart_tx,
    output logic       tx_busy,
    output logic       pkt_done
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_CNT_LAST = CW'(DIV - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;

    localparam logic [7:0] c_TYPE_SCORE = 8'h01;
    localparam logic [7:0] c_TYPE_OVER  = 8'h02;
    localparam logic [7:0] c_TYPE_START = 8'h03;

    logic [3:0]    prev_s1_q, prev_s1_d;
    logic [3:0]    prev_s2_q, prev_s2_d;
    logic          prev_go_q, prev_go_d;
    logic          prev_su_q, prev_su_d;
    logic          pend_score_q, pend_score_d;
    logic          pend_over_q, pend_over_d;
    logic          pend_start_q, pend_start_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    sb_q, sb_d;
    logic [7:0]    type_q, type_d;
    logic [7:0]    chk_q, chk_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic       ev_score;
    logic       ev_over;
    logic       ev_start;
    logic       load;
    logic [7:0] cur_byte;

    always_comb begin
        ev_score  = (score_p1 != prev_s1_q) | (score_p2 != prev_s2_q);
        ev_over   = game_over & ~prev_go_q;
        ev_start  = game_startup & ~prev_su_q;
        load      = (state_q == c_ST_LOAD);

        prev_s1_d = score_p1;
        prev_s2_d = score_p2;
        prev_go_d = game_over;
        prev_su_d = game_startup;

        // A new event in the load cycle survives the clear for the next packet
        pend_score_d = (pend_score_q & ~load) | ev_score;
        pend_over_d  = (pend_over_q  & ~load) | ev_over;
        pend_start_d = (pend_start_q & ~load) | ev_start;

        case (byte_idx_q)
            2'd0:    cur_byte = SYNC_BYTE;
            2'd1:    cur_byte = type_q;
            2'd2:    cur_byte = sb_q;
            default: cur_byte = chk_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sb_d       = sb_q;
        type_d     = type_q;
        chk_d      = chk_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                if (pend_score_q | pend_over_q | pend_start_q) begin
                    state_d = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                sb_d = {score_p1, score_p2};
                if (pend_over_q) begin
                    type_d = c_TYPE_OVER;
                end else if (pend_score_q) begin
                    type_d = c_TYPE_SCORE;
                end else begin
                    type_d = c_TYPE_START;
                end
                chk_d      = SYNC_BYTE ^ type_d ^ sb_d;
                byte_idx_d = 2'd0;
                bit_idx_d  = 4'd0;
                cnt_d      = '0;
                tx_d       = 1'b0;
                busy_d     = 1'b1;
                state_d    = c_ST_SEND;
            end
            c_ST_SEND: begin
                if (cnt_q != c_CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (bit_idx_q == 4'd9) begin
                        if (byte_idx_q == 2'd3) begin
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = c_ST_IDLE;
                        end else begin
                            // Next start bit follows the stop bit directly
                            byte_idx_d = byte_idx_q + 2'd1;
                            bit_idx_d  = 4'd0;
                            tx_d       = 1'b0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = (bit_idx_q == 4'd8) ? 1'b1 : cur_byte[bit_idx_q[2:0]];
                    end
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            prev_s1_q    <= 4'd0;
            prev_s2_q    <= 4'd0;
            prev_go_q    <= 1'b0;
            prev_su_q    <= 1'b0;
            pend_score_q <= 1'b0;
            pend_over_q  <= 1'b0;
            pend_start_q <= 1'b0;
            state_q      <= c_ST_IDLE;
            sb_q         <= 8'd0;
            type_q       <= 8'd0;
            chk_q        <= 8'd0;
            byte_idx_q   <= 2'd0;
            bit_idx_q    <= 4'd0;
            cnt_q        <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            prev_s1_q    <= prev_s1_d;
            prev_s2_q    <= prev_s2_d;
            prev_go_q    <= prev_go_d;
            prev_su_q    <= prev_su_d;
            pend_score_q <= pend_score_d;
            pend_over_q  <= pend_over_d;
            pend_start_q <= pend_start_d;
            state_q      <= state_d;
            sb_q         <= sb_d;
            type_q       <= type_d;
            chk_q        <= chk_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            cnt_q        <= cnt_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign uart_tx  = tx_q;
    assign tx_busy  = busy_q;
    assign pkt_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_telemetry_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_telemetry_tx
// Brief    : Directed stimulus with a byte scoreboard fed by a UART line monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_pong_telemetry_tx;

    localparam int DIV = 218;

    logic       clk_0 = 1'b0;
    logic       rst   = 1'b0;
    logic [3:0] score_p1 = 4'd0;
    logic [3:0] score_p2 = 4'd0;
    logic       game_over = 1'b0;
    logic       game_startup = 1'b0;
    logic       uart_tx;
    logic       tx_busy;
    logic       pkt_done;

    pong_telemetry_tx #(
        .CLK_FREQ (25_175_000),
        .BAUD     (115200),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_0       (clk_0),
        .rst         (rst),
        .score_p1    (score_p1),
        .score_p2    (score_p2),
        .game_over   (game_over),
        .game_startup(game_startup),
        .uart_tx     (uart_tx),
        .tx_busy     (tx_busy),
        .pkt_done    (pkt_done)
    );

    always #5 clk_0 = ~clk_0;

    int cyc = 0;
    always @(posedge clk_0) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int start_hist[$];
    int done_hist[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    int rx_pos = 0;
    int cur_start = 0;

    function automatic void chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic int hist_at(int which, int idx);
        if (which == 0) return (idx < start_hist.size()) ? start_hist[idx] : -1;
        return (idx < done_hist.size()) ? done_hist[idx] : -1;
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk_0);
    endtask

    task automatic push4(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        exp_q.push_back(b3);
    endtask

    task automatic wait_done(string name, int target, int limit);
        int t;
        t = 0;
        while (n_done < target && t < limit) begin
            @(negedge clk_0);
            t++;
        end
        chk(name, n_done, target);
    endtask

    // Line monitor: decodes each frame at mid-bit and scores it against exp_q
    logic [7:0] mon_b;
    bit         mon_ok;
    bit         mon_abort;
    int         mon_k;
    initial begin
        forever begin
            @(negedge clk_0);
            if (rst && uart_tx === 1'b0) begin
                if (rx_pos == 0) begin
                    cur_start = cyc;
                    start_hist.push_back(cyc);
                end
                mon_b     = 8'h00;
                mon_ok    = 1'b1;
                mon_abort = 1'b0;
                for (int c = 0; c < 10 * DIV; c++) begin
                    if (c > 0) @(negedge clk_0);
                    if (!rst) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    if (c % DIV == DIV / 2) begin
                        mon_k = c / DIV;
                        if (mon_k == 0 && uart_tx !== 1'b0) mon_ok = 1'b0;
                        else if (mon_k == 9 && uart_tx !== 1'b1) mon_ok = 1'b0;
                        else if (mon_k >= 1 && mon_k <= 8) mon_b[mon_k-1] = uart_tx;
                        if (tx_busy !== 1'b1) mon_ok = 1'b0;
                    end
                end
                if (mon_abort) begin
                    rx_pos = 0;
                end else begin
                    chk("frame_start_stop_busy", int'(mon_ok), 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", int'(mon_b), -1);
                    end else begin
                        chk($sformatf("byte%0d", rx_pos), int'(mon_b), int'(exp_q.pop_front()));
                    end
                    rx_pos = (rx_pos + 1) % 4;
                end
            end
        end
    end

    // Packet-end monitor: pkt_done must land exactly 40 bit times after the first start bit
    initial begin
        forever begin
            @(negedge clk_0);
            if (rst && pkt_done === 1'b1) begin
                n_done++;
                done_hist.push_back(cyc);
                chk("pkt_len_cycles", cyc - cur_start, 40 * DIV);
                chk("pkt_done_tx_busy_low", int'(tx_busy), 0);
                chk("pkt_done_all_bytes", rx_pos, 0);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        int idle_bad;
        int t;

        // Reset state
        step(5);
        chk("reset_uart_tx", int'(uart_tx), 1);
        chk("reset_tx_busy", int'(tx_busy), 0);
        chk("reset_pkt_done", int'(pkt_done), 0);
        rst = 1'b1;

        // Idle line with all inputs at zero
        idle_bad = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk_0);
            if (uart_tx !== 1'b1 || tx_busy !== 1'b0 || pkt_done !== 1'b0) idle_bad++;
        end
        chk("idle_line_quiet", idle_bad, 0);

        // Score 0/0 -> 3/1
        score_p1 = 4'd3;
        score_p2 = 4'd1;
        e = cyc + 1;
        push4(8'hA5, 8'h01, 8'h31, 8'h95);
        wait_done("score_pkt_done", 1, 12000);
        chk("score_start_latency", hist_at(0, 0), e + 2);
        step(10);

        // Score and game_over in the same cycle: one OVER packet only
        score_p1  = 4'd9;
        score_p2  = 4'd7;
        game_over = 1'b1;
        push4(8'hA5, 8'h02, 8'h97, 8'h30);
        wait_done("simul_pkt_done", 2, 12000);
        step(500);
        chk("simul_no_second_pkt", n_done, 2);

        // Coalescing: several events during a packet give one follow-up
        game_over = 1'b0;
        score_p1  = 4'd0;
        score_p2  = 4'd0;
        push4(8'hA5, 8'h01, 8'h00, 8'hA4);
        push4(8'hA5, 8'h01, 8'h30, 8'h94);
        step(1000);
        score_p1 = 4'd1;
        step(500);
        score_p1 = 4'd2;
        step(500);
        score_p1     = 4'd3;
        game_startup = 1'b1;
        wait_done("coalesce_pkts_done", 4, 20000);
        chk("coalesce_gap", hist_at(0, 3), hist_at(1, 2) + 2);
        step(500);
        chk("coalesce_single_followup", n_done, 4);

        // Startup asserted while reset releases
        rst      = 1'b0;
        score_p1 = 4'd0;
        score_p2 = 4'd0;
        step(5);
        rst = 1'b1;
        push4(8'hA5, 8'h03, 8'h00, 8'hA6);
        wait_done("startup_pkt_done", 5, 12000);
        step(500);
        chk("startup_single_pkt", n_done, 5);

        // Reset in the middle of byte 2
        score_p1 = 4'd5;
        score_p2 = 4'd2;
        push4(8'hA5, 8'h01, 8'h52, 8'hF6);
        t = 0;
        while (rx_pos != 2 && t < 12000) begin
            @(negedge clk_0);
            t++;
        end
        chk("midpkt_reached_byte2", rx_pos, 2);
        step(500);
        #2;
        rst = 1'b0;
        #1;
        chk("midpkt_reset_tx_high", int'(uart_tx), 1);
        chk("midpkt_reset_busy_low", int'(tx_busy), 0);
        chk("midpkt_bytes_left", exp_q.size(), 2);
        exp_q.delete();
        step(5);
        rst = 1'b1;
        push4(8'hA5, 8'h01, 8'h52, 8'hF6);
        wait_done("fresh_pkt_done", 6, 12000);
        step(500);
        chk("fresh_single_pkt", n_done, 6);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("packets_started", start_hist.size(), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
